// File: rtl/parity_sched_pkg.sv
// Shared types, default sizes and the round-robin pick function for the
// parity frame scheduler.
package parity_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NREQ   = 4;
    localparam int RR_MAX     = 32;

    // One-hot pick of the first set request at or after ptr, wrapping at n.
    // Callers must keep n below RR_MAX.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] req_vec,
        input int                ptr,
        input int                n
    );
        logic [RR_MAX-1:0] pick;
        logic              found;
        int                idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (!found && req_vec[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/parity_accum.sv
// Serial odd-parity accumulator: XORs in one bit per valid cycle,
// cleared by load or reset.
module parity_accum (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic valid,
    input  logic din,
    output logic acc
);

    logic r_acc;

    always_ff @(posedge clk) begin
        if (!rst || load) r_acc <= 1'b0;
        else if (valid)   r_acc <= r_acc ^ din;
    end

    assign acc = r_acc;

endmodule

// File: rtl/parity_frame_sched.sv
// Round-robin scheduler feeding one requester word at a time through the
// serial parity accumulator and presenting word + odd parity downstream.
module parity_frame_sched
    import parity_sched_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int NREQ   = DEF_NREQ,
    localparam int SRC_W  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] data,
    output logic [NREQ-1:0]        gnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_parity,
    output logic [SRC_W-1:0]       out_src,
    output logic                   busy
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_word;
    logic [SRC_W-1:0]    r_src;
    logic [SRC_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_cnt;

    logic [RR_MAX-1:0]   w_pick_all;
    logic                w_pick_unused;
    logic [NREQ-1:0]     w_gnt;
    logic [SRC_W-1:0]    w_win_idx;
    logic [SRC_W-1:0]    w_ptr_nxt;
    logic                w_load;
    logic                w_valid;
    logic                w_acc;

    assign w_pick_all    = rr_pick(RR_MAX'(req), int'(r_ptr), NREQ);
    assign w_pick_unused = |w_pick_all[RR_MAX-1:NREQ];
    // Grants exist only in IDLE and are held off while reset is asserted.
    assign w_gnt = (r_state == IDLE && rst) ? w_pick_all[NREQ-1:0] : '0;

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_win_idx = SRC_W'(i);
        end
    end

    assign w_ptr_nxt = (int'(w_win_idx) == NREQ - 1) ? '0 : w_win_idx + SRC_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            IDLE:   if (|w_gnt) w_state_nxt = LOAD;
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                w_valid = 1'b1;
                if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = RESULT;
            end
            RESULT: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_word  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_shift <= data[int'(w_win_idx)*DATA_W +: DATA_W];
                        r_word  <= data[int'(w_win_idx)*DATA_W +: DATA_W];
                        r_src   <= w_win_idx;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                LOAD:  r_cnt <= '0;
                SHIFT: begin
                    r_shift <= r_shift >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    parity_accum u_accum (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .valid (w_valid),
        .din   (r_shift[0]),
        .acc   (w_acc)
    );

    assign gnt        = w_gnt;
    assign out_valid  = (r_state == RESULT);
    assign out_parity = (r_state == RESULT) & ~w_acc;
    assign out_data   = r_word;
    assign out_src    = r_src;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_parity_frame_sched.sv
// Directed bench for parity_frame_sched: table-driven single words plus
// round-robin, stall, mid-shift reset and busy-request sequences.
module tb_parity_frame_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_parity;
    logic [1:0]  out_src;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_frame_sched #(.DATA_W(8), .NREQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .gnt        (gnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_src    (out_src),
        .busy       (busy)
    );

    typedef struct {
        int         src;
        logic [7:0] word;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Wait for out_valid, returning how many cycles it took (budget-limited).
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step;
            n++;
        end
        if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_vec(input int src, input logic [7:0] w, input logic par);
        int n;
        data[src*8 +: 8] = w;
        req = 4'(1 << src);
        #1;
        chk("vec_gnt", 32'(gnt), 32'(1 << src));
        step;
        req = '0;
        wait_valid(n);
        chk("vec_latency", 32'(n + 1), 32'd10);
        chk("vec_data", 32'(out_data), 32'(w));
        chk("vec_parity", 32'(out_parity), 32'(par));
        chk("vec_src", 32'(out_src), 32'(src));
        step;
        chk("vec_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, ng, cyc, hits;
        int gidx[5];
        int gcyc[5];

        vecs[0] = '{src: 2, word: 8'h07, par: 1'b0};
        vecs[1] = '{src: 0, word: 8'h00, par: 1'b1};
        vecs[2] = '{src: 0, word: 8'hFF, par: 1'b1};
        vecs[3] = '{src: 0, word: 8'h01, par: 1'b0};
        vecs[4] = '{src: 0, word: 8'h80, par: 1'b0};
        vecs[5] = '{src: 3, word: 8'hA5, par: 1'b1};
        vecs[6] = '{src: 1, word: 8'h7F, par: 1'b0};
        vecs[7] = '{src: 2, word: 8'h6E, par: 1'b0};

        rst = 1'b0;
        req = '0;
        data = '0;
        out_ready = 1'b1;
        step; step; step;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_parity", 32'(out_parity), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        rst = 1'b1;
        step;

        // The src/word table uses one requester at a time, so latency is fixed.
        for (int i = 0; i < 8; i++) run_vec(vecs[i].src, vecs[i].word, vecs[i].par);

        // Back-to-back round robin: after the table the pointer sits at 3.
        // Bring it back to 0 by a reset so the order starts at requester 0.
        rst = 1'b0;
        step;
        rst = 1'b1;
        data = 32'h44332211;
        req = 4'hF;
        ng = 0;
        cyc = 0;
        #1;
        while (ng < 5 && cyc < 80) begin
            if (|gnt) begin
                gidx[ng] = oh2idx(gnt);
                gcyc[ng] = cyc;
                ng++;
            end
            step;
            cyc++;
        end
        req = '0;
        chk("rr_count", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < ng) chk("rr_order", 32'(gidx[i]), 32'(i % 4));
            if (i > 0 && i < ng) chk("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd11);
        end
        n = 0;
        while (busy && n < 40) begin
            step;
            n++;
        end
        chk("rr_drain", 32'(busy), 32'd0);

        // Stall in RESULT with another requester waiting.
        out_ready = 1'b0;
        data[15:8] = 8'h3C;
        req = 4'b0010;
        #1;
        chk("stall_gnt", 32'(gnt), 32'd2);
        step;
        req = 4'b1000;
        data[31:24] = 8'h99;
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'h3C);
            chk("stall_parity", 32'(out_parity), 32'd1);
            chk("stall_src", 32'(out_src), 32'd1);
            chk("stall_gnt_low", 32'(gnt), 32'd0);
            step;
        end
        out_ready = 1'b1;
        #1;
        chk("stall_hs_gnt", 32'(gnt), 32'd0);
        step;
        chk("stall_next_gnt", 32'(gnt), 32'd8);
        step;
        req = '0;
        wait_valid(n);
        chk("stall_next_data", 32'(out_data), 32'h99);
        chk("stall_next_parity", 32'(out_parity), 32'd1);
        chk("stall_next_src", 32'(out_src), 32'd3);
        step;

        // Reset in the middle of shifting 0xA5 out of requester 2.
        data[23:16] = 8'hA5;
        req = 4'b0100;
        #1;
        chk("abort_gnt", 32'(gnt), 32'd4);
        step;
        req = '0;
        repeat (5) step;
        rst = 1'b0;
        step;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_data", 32'(out_data), 32'd0);
        chk("abort_parity", 32'(out_parity), 32'd0);
        chk("abort_src", 32'(out_src), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_gnt_low", 32'(gnt), 32'd0);
        rst = 1'b1;
        hits = 0;
        repeat (15) begin
            step;
            if (out_valid) hits++;
        end
        chk("abort_no_result", 32'(hits), 32'd0);
        data[7:0] = 8'h11;
        req = 4'b0101;
        #1;
        chk("abort_next_gnt", 32'(gnt), 32'd1);
        step;
        req = '0;
        wait_valid(n);
        chk("abort_next_src", 32'(out_src), 32'd0);
        chk("abort_next_parity", 32'(out_parity), 32'd1);
        step;

        // Request raised and dropped entirely inside a busy window.
        data[7:0] = 8'h0F;
        data[15:8] = 8'hF0;
        req = 4'b0001;
        #1;
        chk("busy_gnt", 32'(gnt), 32'd1);
        step;
        req = '0;
        hits = 0;
        repeat (3) begin
            step;
            if (|gnt) hits++;
        end
        req = 4'b0010;
        repeat (3) begin
            step;
            if (|gnt) hits++;
        end
        req = '0;
        n = 0;
        while (busy && n < 40) begin
            step;
            n++;
            if (|gnt) hits++;
        end
        repeat (4) begin
            step;
            if (|gnt) hits++;
        end
        chk("busy_no_gnt", 32'(hits), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_sched.md
# parity_frame_sched

Round-robin scheduler sharing one serial odd-parity accumulator among NREQ requesters. It grants one requester at a time and captures its DATA_W-bit word. It then drives the accumulator's load/valid/din sequence bit-serially and presents the word plus its odd-parity bit on a valid/ready output port, tagged with the source index. It sits between parallel word producers and the serial link framer.

## Interface
- DATA_W, 8: word width; must be ≥ 2.
- NREQ, 4: number of requesters; must be ≥ 2.
- SRC_W, $clog2(NREQ): derived, width of the source tag.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester request; held with its data until granted.
- data  in  NREQ*DATA_W  requester words; slice i is bits [i*DATA_W +: DATA_W].
- gnt  out  NREQ  one-hot, one-cycle grant; data[i] is captured on that edge.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  captured word.
- out_parity  out  1  odd-parity bit: XOR(out_data, out_parity) = 1.
- out_src  out  SRC_W  index of the granted requester.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, SHIFT, RESULT.
- **IDLE:**
  - If any req is high, gnt is asserted combinationally to the winner.
  - On the same edge: data slice → shift register, index → out_src, rr pointer ← winner+1 (mod NREQ); go to LOAD.
  - If no req, remain in IDLE with gnt = 0.
- **LOAD:** accumulator load = 1 for one cycle, clearing it to 0. Bit counter ← 0. Go to SHIFT.
- **SHIFT:**
  - valid = 1 and din = shift-register LSB each cycle; shift right; counter increments.
  - Words are sent LSB first.
  - After DATA_W cycles (counter = DATA_W-1 on the last cycle), go to RESULT.
- **RESULT:**
  - out_valid = 1; out_parity = ~acc; out_data is the original captured word, held in a separate register from the shift register.
  - Outputs stay stable until out_valid && out_ready, then return to IDLE.
- **Arbitration:** round-robin. Search starts at the rr pointer and wraps modulo NREQ. After reset the pointer is 0, so req[0] has first priority.
- **Reset (rst = 0 at a clock edge):**
  - state ← IDLE; gnt = 0, out_valid = 0, out_data = 0, out_parity = 0, out_src = 0, busy = 0.
  - Accumulator ← 0, rr pointer ← 0.
  - Reset mid-operation abandons the word; no result is emitted.
- **Boundary conditions:**
  - Requests arriving while busy are ignored until IDLE; no queuing.
  - A req dropped before being granted is simply not serviced.
  - A requester may keep req high for back-to-back words; the next grant to it follows round-robin order.
  - Accumulator load and valid are never asserted together.

## Timing
- Grant at cycle T (IDLE) → LOAD at T+1 → SHIFT at T+2 … T+1+DATA_W → out_valid at T+2+DATA_W.
- With out_ready held high: RESULT lasts 1 cycle, IDLE at T+3+DATA_W, next grant possible in that same cycle. Period is DATA_W+3 cycles per word.
- out_ready low stalls in RESULT indefinitely; out_* are stable throughout.
- gnt is only ever high in IDLE; it is never high while busy = 1.

## Structure
- Package parity_sched_pkg:
  - state enum {IDLE, LOAD, SHIFT, RESULT};
  - default DATA_W and NREQ constants;
  - round-robin pick function (request vector, pointer → one-hot grant).
- Sub-module parity_accum:
  - inputs clk, rst, load, valid, din; output acc;
  - acc ← 0 on reset or load, else acc ← acc ^ din when valid.
- The top level holds the FSM, arbiter, shift register, bit counter and output registers.

## Test plan
- Single request, req[2] with data 0x07: gnt[2] at T; out_valid at T+10; out_data = 0x07, out_parity = 0, out_src = 2.
- Data values on req[0]:
  - 0x00 → out_parity = 1.
  - 0xFF → out_parity = 1.
  - 0x01 → out_parity = 0.
  - 0x80 → out_parity = 0.
- All four req held high with out_ready = 1: grants in order 0, 1, 2, 3, 0; consecutive grants exactly 11 cycles apart.
- out_ready low for 5 cycles in RESULT: out_valid, out_data, out_parity and out_src remain stable; no new gnt until the cycle after the handshake.
- rst driven low during SHIFT (bit 4 of 0xA5):
  - next cycle all outputs are 0 and state is IDLE;
  - no out_valid for the aborted word;
  - the next grant goes to req[0] when pending.
- req[1] raised while busy and dropped before returning to IDLE: never granted; gnt stays 0 throughout.
